// File: rtl/mc16_pin_mem_responder.sv
// Pin-bus memory responder for microcore16: byte-serial address/data in, 16-bit word memory, ack strobe out.
// Optional sticky bus-contention flag on `err` when MC16_RSP_CONTENTION_CHK_EN is defined.
module mc16_pin_mem_responder #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pin_req,
  input  logic          pin_we,
  input  logic [7:0]    pin_bus_out,
  input  logic [7:0]    pin_bus_oe,
  output logic          pin_ack,
  output logic [7:0]    pin_bus_in,
  output logic          rsp_drive,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic          busy
`ifdef MC16_RSP_CONTENTION_CHK_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, DATA_LO, DATA_HI, WR_ACK, TURN, RD_LO, RD_HI, WAIT_REL
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [7:0]    wlo_q, wlo_d;
  logic [7:0]    rd_hi_q, rd_hi_d;
  logic          ack_q, ack_d;
  logic          drive_q, drive_d;
  logic [7:0]    bus_q, bus_d;
  logic          busy_q, busy_d;
  logic          commit;
  logic          wr_en;

  logic [15:0]   mem_q [2**AW];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wlo_d   = wlo_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (pin_req) begin
        addr_d  = AW'(pin_bus_out);
        we_d    = pin_we;
        state_d = ADDR_HI;
      end
      ADDR_HI: if (!pin_req) state_d = IDLE;
      else begin
        // Upper address bits beyond AW are dropped, so addresses alias.
        addr_d  = AW'({pin_bus_out, 8'(addr_q)});
        state_d = we_q ? DATA_LO : TURN;
      end
      DATA_LO: if (!pin_req) state_d = IDLE;
      else begin
        wlo_d   = pin_bus_out;
        state_d = DATA_HI;
      end
      DATA_HI: if (!pin_req) state_d = IDLE;
      else begin
        commit  = 1'b1;
        state_d = WR_ACK;
      end
      WR_ACK:   state_d = WAIT_REL;
      TURN:     state_d = pin_req ? RD_LO : IDLE;
      RD_LO:    state_d = RD_HI;
      RD_HI:    state_d = WAIT_REL;
      WAIT_REL: if (!pin_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    ack_d   = state_d inside {WR_ACK, RD_LO, RD_HI};
    drive_d = state_d inside {RD_LO, RD_HI};
    busy_d  = state_d != IDLE;
    rd_hi_d = rd_hi_q;
    bus_d   = 8'h00;
    if (state_d == RD_LO) begin
      bus_d   = mem_q[addr_q][7:0];
      rd_hi_d = mem_q[addr_q][15:8];
    end else if (state_d == RD_HI) begin
      bus_d = rd_hi_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wlo_q   <= 8'h00;
      rd_hi_q <= 8'h00;
      ack_q   <= 1'b0;
      drive_q <= 1'b0;
      bus_q   <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wlo_q   <= wlo_d;
      rd_hi_q <= rd_hi_d;
      ack_q   <= ack_d;
      drive_q <= drive_d;
      bus_q   <= bus_d;
      busy_q  <= busy_d;
    end
  end

  // Memory has no reset; a reset on the commit edge must still drop the write.
  assign wr_en = commit && rst_n;

  always_ff @(posedge clk) begin
    if (wr_en)   mem_q[addr_q]    <= {pin_bus_out, wlo_q};
    if (load_en) mem_q[load_addr] <= load_data;
  end

  assign pin_ack    = ack_q;
  assign rsp_drive  = drive_q;
  assign pin_bus_in = bus_q;
  assign busy       = busy_q;

`ifdef MC16_RSP_CONTENTION_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if ((drive_q || state_q == TURN) && (pin_bus_oe != 8'h00))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_oe;
  assign unused_oe = ^pin_bus_oe;
`endif

endmodule

// File: tb/tb_mc16_pin_mem_responder.sv
// Bench for mc16_pin_mem_responder: table of write/read/load vectors with a byte scoreboard, plus corner sequences.
module tb_mc16_pin_mem_responder;

  localparam int OP_W = 0;
  localparam int OP_R = 1;
  localparam int OP_L = 2;

  typedef struct {
    int          op;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pin_req;
  logic        pin_we;
  logic [7:0]  pin_bus_out;
  logic [7:0]  pin_bus_oe;
  logic        pin_ack;
  logic [7:0]  pin_bus_in;
  logic        rsp_drive;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic        busy;
`ifdef MC16_RSP_CONTENTION_CHK_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];
  vec_t vecs [11];

  mc16_pin_mem_responder #(.AW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_req    (pin_req),
    .pin_we     (pin_we),
    .pin_bus_out(pin_bus_out),
    .pin_bus_oe (pin_bus_oe),
    .pin_ack    (pin_ack),
    .pin_bus_in (pin_bus_in),
    .rsp_drive  (rsp_drive),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .busy       (busy)
`ifdef MC16_RSP_CONTENTION_CHK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a[7:0]; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    pin_req = 1'b1; pin_we = 1'b1; pin_bus_out = a[7:0]; pin_bus_oe = 8'hFF;
    tick();
    chk("wr_busy_c1", busy, 1);
    chk("wr_ack_c1", pin_ack, 0);
    pin_we = 1'b0; pin_bus_out = a[15:8];
    tick();
    pin_bus_out = d[7:0];
    tick();
    chk("wr_ack_c3", pin_ack, 0);
    pin_bus_out = d[15:8];
    tick();
    chk("wr_ack_c4", pin_ack, 1);
    chk("wr_drive_c4", rsp_drive, 0);
    pin_req = 1'b0; pin_bus_oe = 8'h00; pin_bus_out = 8'h00;
    tick();
    chk("wr_ack_c5", pin_ack, 0);
    chk("wr_busy_c5", busy, 1);
    tick();
    chk("wr_busy_idle", busy, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp[7:0]);
    exp_q.push_back(exp[15:8]);
    pin_req = 1'b1; pin_we = 1'b0; pin_bus_out = a[7:0]; pin_bus_oe = 8'hFF;
    tick();
    pin_bus_out = a[15:8];
    tick();
    pin_bus_oe = 8'h00; pin_bus_out = 8'h00;
    chk("rd_turn_drive", rsp_drive, 0);
    chk("rd_turn_bus", pin_bus_in, 0);
    chk("rd_turn_ack", pin_ack, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      if (exp_q.size() == 0) begin
        chk("rd_queue_empty", 1, 0);
        e = 8'h00;
      end else begin
        e = exp_q.pop_front();
      end
      chk(k == 0 ? "rd_lo_byte" : "rd_hi_byte", pin_bus_in, e);
      chk(k == 0 ? "rd_lo_ack" : "rd_hi_ack", pin_ack, 1);
      chk(k == 0 ? "rd_lo_drive" : "rd_hi_drive", rsp_drive, 1);
      if (k == 1) pin_req = 1'b0;
      tick();
    end
    chk("rd_c5_ack", pin_ack, 0);
    chk("rd_c5_drive", rsp_drive, 0);
    chk("rd_c5_bus", pin_bus_in, 0);
    tick();
    chk("rd_busy_idle", busy, 0);
  endtask

  initial begin
    vecs[0]  = '{OP_W, 16'h0012, 16'hBEEF};
    vecs[1]  = '{OP_R, 16'h0012, 16'hBEEF};
    vecs[2]  = '{OP_L, 16'h0005, 16'h1234};
    vecs[3]  = '{OP_R, 16'h0105, 16'h1234};
    vecs[4]  = '{OP_W, 16'h03FF, 16'h8001};
    vecs[5]  = '{OP_R, 16'h00FF, 16'h8001};
    vecs[6]  = '{OP_W, 16'h0000, 16'h00FF};
    vecs[7]  = '{OP_R, 16'h0100, 16'h00FF};
    vecs[8]  = '{OP_W, 16'h0012, 16'h55AA};
    vecs[9]  = '{OP_R, 16'h0012, 16'h55AA};
    vecs[10] = '{OP_R, 16'hFF05, 16'h1234};

    rst_n = 1'b0; pin_req = 1'b0; pin_we = 1'b0; pin_bus_out = 8'h00; pin_bus_oe = 8'h00;
    load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0000;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("rst_ack", pin_ack, 0);
    chk("rst_bus", pin_bus_in, 0);
    chk("rst_drive", rsp_drive, 0);
    chk("rst_busy", busy, 0);
`ifdef MC16_RSP_CONTENTION_CHK_EN
    chk("rst_err", err, 0);
`endif

    for (int i = 0; i < 11; i++) begin
      case (vecs[i].op)
        OP_W:    do_write(vecs[i].addr, vecs[i].data);
        OP_R:    do_read(vecs[i].addr, vecs[i].data);
        default: do_load(vecs[i].addr, vecs[i].data);
      endcase
    end

    // Abort during DATA_LO: no write, busy drops next cycle
    do_load(16'h0007, 16'h5555);
    pin_req = 1'b1; pin_we = 1'b1; pin_bus_out = 8'h07; pin_bus_oe = 8'hFF;
    tick();
    pin_we = 1'b0; pin_bus_out = 8'h00;
    tick();
    pin_req = 1'b0; pin_bus_out = 8'hAA;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_ack", pin_ack, 0);
    pin_bus_oe = 8'h00; pin_bus_out = 8'h00;
    do_read(16'h0007, 16'h5555);

    // DATA_HI commit colliding with a backdoor load to the same word
    pin_req = 1'b1; pin_we = 1'b1; pin_bus_out = 8'h09; pin_bus_oe = 8'hFF;
    tick();
    pin_we = 1'b0; pin_bus_out = 8'h00;
    tick();
    pin_bus_out = 8'h11;
    tick();
    pin_bus_out = 8'h11; load_en = 1'b1; load_addr = 8'h09; load_data = 16'h2222;
    tick();
    load_en = 1'b0;
    chk("collide_ack", pin_ack, 1);
    pin_req = 1'b0; pin_bus_oe = 8'h00; pin_bus_out = 8'h00;
    tick(); tick();
    do_read(16'h0009, 16'h2222);

    // Abort in TURN
    pin_req = 1'b1; pin_we = 1'b0; pin_bus_out = 8'h05; pin_bus_oe = 8'hFF;
    tick();
    pin_bus_out = 8'h00;
    tick();
    pin_req = 1'b0; pin_bus_oe = 8'h00;
    tick();
    chk("turn_abort_busy", busy, 0);
    chk("turn_abort_drive", rsp_drive, 0);
    chk("turn_abort_ack", pin_ack, 0);

    // Reset in DATA_HI loses the write
    do_load(16'h0020, 16'h1357);
    pin_req = 1'b1; pin_we = 1'b1; pin_bus_out = 8'h20; pin_bus_oe = 8'hFF;
    tick();
    pin_we = 1'b0; pin_bus_out = 8'h00;
    tick();
    pin_bus_out = 8'hFF;
    tick();
    pin_bus_out = 8'hFF; rst_n = 1'b0;
    tick();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ack", pin_ack, 0);
    rst_n = 1'b1; pin_req = 1'b0; pin_bus_oe = 8'h00; pin_bus_out = 8'h00;
    tick();
    do_read(16'h0020, 16'h1357);

`ifdef MC16_RSP_CONTENTION_CHK_EN
    pin_req = 1'b1; pin_we = 1'b0; pin_bus_out = 8'h05; pin_bus_oe = 8'hFF;
    tick();
    pin_bus_out = 8'h00;
    tick();
    pin_bus_oe = 8'h00;
    tick();
    chk("err_before", err, 0);
    pin_bus_oe = 8'hFF;
    tick();
    chk("err_set", err, 1);
    pin_bus_oe = 8'h00; pin_req = 1'b0;
    tick(); tick(); tick();
    chk("err_sticky", err, 1);
    rst_n = 1'b0;
    tick();
    chk("err_reset", err, 0);
    rst_n = 1'b1;
    tick();
`endif

    chk("queue_drained", 16'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
